// File: rtl/frame_line_sequencer_pkg.sv
// ============================================================================
// Module : frame_line_sequencer_pkg
// Brief  : State encoding and default geometry widths for the line sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package frame_line_sequencer_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_LW = 12;
  localparam int unsigned DEF_LH = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/frame_line_sequencer.sv
// ============================================================================
// Module : frame_line_sequencer
// Brief  : Turns frame-start strobes into paced per-line fetch requests.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_line_sequencer
  import frame_line_sequencer_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned LW = DEF_LW,
  parameter int unsigned LH = DEF_LH
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic          i_frame_stb,
  input  logic [AW-1:0] i_baseaddr,
  input  logic [LW-1:0] i_line_words,
  input  logic [LH-1:0] i_nlines,
  output logic          o_req,
  output logic [AW-1:0] o_addr,
  output logic [LW-1:0] o_len,
  input  logic          i_ready,
  input  logic          i_line_done,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_overrun
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LH-1:0] nlines_q, nlines_d;
  logic [LH-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;

  logic          w_start_req;
  logic          w_geom_ok;
  logic          w_last_line;
  logic [AW-1:0] w_step;

  assign w_start_req = (i_frame_stb || pending_q) && i_en;
  assign w_geom_ok   = (i_line_words != '0) && (i_nlines != '0);
  assign w_last_line = (cnt_q == (nlines_q - 1'b1));
  assign w_step      = {{(AW-LW){1'b0}}, len_q};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      nlines_q     <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      nlines_q     <= nlines_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    nlines_d     = nlines_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start with a degenerate geometry consumes the request silently.
        if (w_start_req) begin
          pending_d = 1'b0;
          if (w_geom_ok) begin
            addr_d   = i_baseaddr;
            len_d    = i_line_words;
            nlines_d = i_nlines;
            cnt_d    = '0;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (i_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_line_done) begin
          if (w_last_line) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = addr_q + w_step;
            state_d = ST_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes during a frame are remembered once and flagged every time.
    if ((state_q != ST_IDLE) && i_frame_stb) begin
      overrun_d = 1'b1;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    o_req        = (state_q == ST_ISSUE);
    o_busy       = (state_q != ST_IDLE);
    o_addr       = addr_q;
    o_len        = len_q;
    o_frame_done = frame_done_q;
    o_overrun    = overrun_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_line_sequencer.sv
// ============================================================================
// Module : tb_frame_line_sequencer
// Brief  : Directed self-checking bench for frame_line_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_line_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stb;
  logic [31:0] base;
  logic [11:0] lw;
  logic [11:0] nl;
  logic        req;
  logic [31:0] addr;
  logic [11:0] len;
  logic        ready;
  logic        done;
  logic        busy;
  logic        fdone;
  logic        ovr;

  int npass = 0;
  int ntotal = 0;

  frame_line_sequencer dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_en         (en),
    .i_frame_stb  (stb),
    .i_baseaddr   (base),
    .i_line_words (lw),
    .i_nlines     (nl),
    .o_req        (req),
    .o_addr       (addr),
    .o_len        (len),
    .i_ready      (ready),
    .i_line_done  (done),
    .o_busy       (busy),
    .o_frame_done (fdone),
    .o_overrun    (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal = ntotal + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic strobe();
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; stb = 1'b0; base = '0; lw = '0; nl = '0;
    ready = 1'b1; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_req", {63'd0, req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_addr", {32'd0, addr}, 64'd0);
    check("rst_len", {52'd0, len}, 64'd0);
    check("rst_fdone", {63'd0, fdone}, 64'd0);
    check("rst_ovr", {63'd0, ovr}, 64'd0);

    // Basic three-line frame; base changes mid-frame must not matter.
    base = 32'h1000; lw = 12'd640; nl = 12'd3;
    strobe();
    check("f1_req0", {63'd0, req}, 64'd1);
    check("f1_addr0", {32'd0, addr}, 64'h1000);
    check("f1_len0", {52'd0, len}, 64'd640);
    check("f1_busy", {63'd0, busy}, 64'd1);
    base = 32'h0; lw = 12'd1; nl = 12'd9;
    tick();
    check("f1_acc0", {63'd0, req}, 64'd0);
    tick(); tick(); tick();
    pulse_done();
    check("f1_req1", {63'd0, req}, 64'd1);
    check("f1_addr1", {32'd0, addr}, 64'h1280);
    tick(); tick(); tick(); tick();
    pulse_done();
    check("f1_addr2", {32'd0, addr}, 64'h1500);
    check("f1_len2", {52'd0, len}, 64'd640);
    tick(); tick(); tick(); tick();
    pulse_done();
    check("f1_fdone", {63'd0, fdone}, 64'd1);
    check("f1_busy_drop", {63'd0, busy}, 64'd0);
    check("f1_req_end", {63'd0, req}, 64'd0);
    tick();
    check("f1_fdone_pulse", {63'd0, fdone}, 64'd0);

    // Back-pressure: request held stable while not ready.
    base = 32'h2000; lw = 12'd16; nl = 12'd1; ready = 1'b0;
    strobe();
    for (int i = 0; i < 5; i++) begin
      check("bp_req_hold", {63'd0, req}, 64'd1);
      check("bp_addr_hold", {32'd0, addr}, 64'h2000);
      check("bp_len_hold", {52'd0, len}, 64'd16);
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("bp_accepted", {63'd0, req}, 64'd0);
    tick(); tick();
    check("bp_one_accept", {63'd0, req}, 64'd0);
    check("bp_busy_wait", {63'd0, busy}, 64'd1);
    pulse_done();
    check("bp_fdone", {63'd0, fdone}, 64'd1);
    ready = 1'b1;
    tick();

    // Overrun: two extra strobes yield two pulses and one queued frame.
    base = 32'h3000; lw = 12'd8; nl = 12'd2;
    strobe();
    strobe();
    check("ov_pulse1", {63'd0, ovr}, 64'd1);
    tick();
    check("ov_gap", {63'd0, ovr}, 64'd0);
    strobe();
    check("ov_pulse2", {63'd0, ovr}, 64'd1);
    pulse_done();
    check("ov_addr1", {32'd0, addr}, 64'h3008);
    check("ov_no_pulse", {63'd0, ovr}, 64'd0);
    tick();
    pulse_done();
    check("ov_fdone", {63'd0, fdone}, 64'd1);
    check("ov_idle_one", {63'd0, busy}, 64'd0);
    tick();
    check("ov_restart_req", {63'd0, req}, 64'd1);
    check("ov_restart_addr", {32'd0, addr}, 64'h3000);
    check("ov_fdone_clear", {63'd0, fdone}, 64'd0);
    tick();
    pulse_done();
    check("ov2_addr1", {32'd0, addr}, 64'h3008);
    tick();
    pulse_done();
    check("ov2_fdone", {63'd0, fdone}, 64'd1);
    tick(); tick(); tick();
    check("ov_no_third", {63'd0, req}, 64'd0);
    check("ov_no_third_busy", {63'd0, busy}, 64'd0);

    // Degenerate geometries and disabled starts are ignored.
    base = 32'h5000; lw = 12'd8; nl = 12'd0;
    strobe();
    check("dg_nl0_req", {63'd0, req}, 64'd0);
    check("dg_nl0_busy", {63'd0, busy}, 64'd0);
    lw = 12'd0; nl = 12'd3;
    strobe();
    check("dg_lw0_req", {63'd0, req}, 64'd0);
    check("dg_lw0_busy", {63'd0, busy}, 64'd0);
    tick();
    check("dg_no_pulse", {62'd0, fdone, ovr}, 64'd0);
    lw = 12'd8; en = 1'b0;
    strobe();
    check("en_low_req", {63'd0, req}, 64'd0);
    en = 1'b1;
    tick();

    // Address wrap at 2^32.
    base = 32'hFFFF_FF00; lw = 12'h100; nl = 12'd2;
    strobe();
    check("wr_addr0", {32'd0, addr}, 64'hFFFF_FF00);
    tick();
    pulse_done();
    check("wr_addr1", {32'd0, addr}, 64'h0);
    check("wr_req1", {63'd0, req}, 64'd1);
    tick();
    pulse_done();
    check("wr_fdone", {63'd0, fdone}, 64'd1);
    tick();

    // Reset in WAIT abandons the frame; stray done is ignored.
    base = 32'h4000; lw = 12'd4; nl = 12'd2;
    strobe();
    tick();
    check("rs_in_wait", {62'd0, busy, req}, 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_busy", {63'd0, busy}, 64'd0);
    check("rs_addr", {32'd0, addr}, 64'd0);
    check("rs_len", {52'd0, len}, 64'd0);
    check("rs_flags", {61'd0, req, fdone, ovr}, 64'd0);
    pulse_done();
    check("rs_stray_fdone", {63'd0, fdone}, 64'd0);
    check("rs_stray_busy", {63'd0, busy}, 64'd0);
    tick();
    check("rs_stay_idle", {62'd0, busy, fdone}, 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire
